// File: rtl/pad_bank_ctrl_if.sv
// Config register access port of the pad bank controller: a request is granted
// in the same cycle and answered one cycle later with rvalid/rdata/err.
interface pad_bank_ctrl_if #(
  parameter int AW = 3
) ();
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [7:0]    wdata;
  logic          gnt;
  logic          rvalid;
  logic [7:0]    rdata;
  logic          err;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/pad_bank_ctrl.sv
// Power-aware sequencer for a bank of 1.8V pads: holds per-pad config, waits for
// stable ring power, then enables pad groups one at a time to limit switching noise.
module pad_bank_ctrl #(
  parameter int         N_PADS            = 8,
  parameter int         GROUP_SIZE        = 2,
  parameter int         STAGGER_CYCLES    = 4,
  parameter int         PWR_STABLE_CYCLES = 16,
  parameter logic [7:0] CFG_RST           = 8'h02
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                rto_i,
  input  logic                sns_i,
  pad_bank_ctrl_if.slave      cfg,
  input  logic [N_PADS-1:0]   core_oe_i,
  input  logic [N_PADS-1:0]   core_ie_i,
  output logic [N_PADS-1:0]   pad_oe_o,
  output logic [N_PADS-1:0]   pad_ie_o,
  output logic [N_PADS-1:0]   pad_pe_o,
  output logic [N_PADS-1:0]   pad_ps_o,
  output logic [2*N_PADS-1:0] pad_ds_o,
  output logic [N_PADS-1:0]   pad_sr_o,
  output logic [N_PADS-1:0]   pad_is_o,
  output logic                bank_ready_o
);

  localparam int NG = (N_PADS + GROUP_SIZE - 1) / GROUP_SIZE;
  localparam int CW = $clog2(PWR_STABLE_CYCLES + 1);
  localparam int SW = $clog2(STAGGER_CYCLES + 1);
  localparam int GW = $clog2(NG + 1);

  typedef enum logic [2:0] {S_OFF, S_WAIT, S_RAMP, S_ACTIVE, S_SAFE} state_e;

  state_e            state_q;
  logic [CW-1:0]     stableCnt_q;
  logic [SW-1:0]     stagCnt_q;
  logic [GW-1:0]     grpIdx_q;
  logic [NG-1:0]     grpEn_q;
  logic              ready_q;
  logic [7:0]        cfg_q [N_PADS];
  logic              rvalid_q;
  logic              err_q;
  logic [7:0]        rdata_q;
  logic [N_PADS-1:0] padOe_q, padIe_q, padPe_q, padPs_q, padSr_q, padIs_q;
  logic [N_PADS-1:0] padOe_d, padIe_d, padPe_d, padPs_d, padSr_d, padIs_d;
  logic [2*N_PADS-1:0] padDs_q, padDs_d;

  logic        pwrOk;
  logic        rampStart;
  logic [31:0] addrExt;
  logic        addrOk;

  assign pwrOk     = rto_i & sns_i;
  assign rampStart = pwrOk &&
                     (((state_q == S_OFF) && (PWR_STABLE_CYCLES == 1)) ||
                      ((state_q == S_WAIT) && (stableCnt_q == CW'(PWR_STABLE_CYCLES - 1))));
  assign addrExt   = 32'(cfg.addr);
  assign addrOk    = addrExt < 32'(N_PADS);

  // stableCnt_q counts consecutive high pwr_ok samples, including the one that left OFF
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_OFF;
      stableCnt_q <= '0;
      stagCnt_q   <= '0;
      grpIdx_q    <= '0;
      grpEn_q     <= '0;
      ready_q     <= 1'b0;
    end else begin
      ready_q <= (state_q == S_ACTIVE) && pwrOk;
      if (!pwrOk) begin
        stableCnt_q <= '0;
        stagCnt_q   <= '0;
        grpIdx_q    <= '0;
        grpEn_q     <= '0;
        state_q     <= ((state_q == S_RAMP) || (state_q == S_ACTIVE)) ? S_SAFE : S_OFF;
      end else if (state_q == S_SAFE) begin
        state_q <= S_OFF;
      end else if (rampStart) begin
        state_q     <= (NG == 1) ? S_ACTIVE : S_RAMP;
        grpEn_q     <= NG'(1);
        grpIdx_q    <= GW'(1);
        stagCnt_q   <= '0;
        stableCnt_q <= '0;
      end else begin
        case (state_q)
          S_OFF: begin
            state_q     <= S_WAIT;
            stableCnt_q <= CW'(1);
          end
          S_WAIT: stableCnt_q <= stableCnt_q + CW'(1);
          S_RAMP: begin
            if (stagCnt_q == SW'(STAGGER_CYCLES - 1)) begin
              stagCnt_q <= '0;
              grpEn_q   <= grpEn_q | (NG'(1) << grpIdx_q);
              grpIdx_q  <= grpIdx_q + GW'(1);
              if (grpIdx_q == GW'(NG - 1)) state_q <= S_ACTIVE;
            end else begin
              stagCnt_q <= stagCnt_q + SW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Gating with live pwr_ok makes the pads drop on the same edge the FSM sees power loss
  always_comb begin
    padOe_d = '0;
    padIe_d = '0;
    padPe_d = '0;
    padPs_d = '0;
    padDs_d = '0;
    padSr_d = '0;
    padIs_d = '0;
    for (int p = 0; p < N_PADS; p++) begin
      if (grpEn_q[p / GROUP_SIZE] && pwrOk) begin
        padOe_d[p]        = core_oe_i[p] & cfg_q[p][0];
        padIe_d[p]        = core_ie_i[p] & cfg_q[p][1];
        padPe_d[p]        = cfg_q[p][2];
        padPs_d[p]        = cfg_q[p][3];
        padDs_d[2*p +: 2] = cfg_q[p][5:4];
        padSr_d[p]        = cfg_q[p][6];
        padIs_d[p]        = cfg_q[p][7];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      padOe_q <= '0;
      padIe_q <= '0;
      padPe_q <= '0;
      padPs_q <= '0;
      padDs_q <= '0;
      padSr_q <= '0;
      padIs_q <= '0;
    end else begin
      padOe_q <= padOe_d;
      padIe_q <= padIe_d;
      padPe_q <= padPe_d;
      padPs_q <= padPs_d;
      padDs_q <= padDs_d;
      padSr_q <= padSr_d;
      padIs_q <= padIs_d;
    end
  end

  // Config survives power loss; only rst_ni restores the reset value
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int p = 0; p < N_PADS; p++) cfg_q[p] <= CFG_RST;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= cfg.req;
      err_q    <= cfg.req && !addrOk;
      rdata_q  <= (cfg.req && !cfg.we && addrOk) ? cfg_q[cfg.addr] : 8'h00;
      if (cfg.req && cfg.we && addrOk) cfg_q[cfg.addr] <= cfg.wdata;
    end
  end

  assign cfg.gnt      = cfg.req;
  assign cfg.rvalid   = rvalid_q;
  assign cfg.err      = err_q;
  assign cfg.rdata    = rdata_q;
  assign pad_oe_o     = padOe_q;
  assign pad_ie_o     = padIe_q;
  assign pad_pe_o     = padPe_q;
  assign pad_ps_o     = padPs_q;
  assign pad_ds_o     = padDs_q;
  assign pad_sr_o     = padSr_q;
  assign pad_is_o     = padIs_q;
  assign bank_ready_o = ready_q;

endmodule

// File: tb/tb_pad_bank_ctrl.sv
// Self-checking bench for pad_bank_ctrl: directed power/cfg scenarios plus random
// traffic, compared against a power-history model kept in the bench.
module tb_pad_bank_ctrl;

  localparam int N   = 8;
  localparam int GS  = 2;
  localparam int ST  = 4;
  localparam int PSC = 16;
  localparam int NG  = 4;
  localparam int N2  = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstN, rto, sns;
  logic [N-1:0]    coreOe, coreIe;
  logic [N-1:0]    padOe, padIe, padPe, padPs, padSr, padIs;
  logic [2*N-1:0]  padDs;
  logic            ready;
  logic [N2-1:0]   padOe2, padIe2, padPe2, padPs2, padSr2, padIs2;
  logic [2*N2-1:0] padDs2;
  logic            ready2;

  pad_bank_ctrl_if #(.AW(3)) cfgIf ();
  pad_bank_ctrl_if #(.AW(4)) cfgIf2 ();

  pad_bank_ctrl #(.N_PADS(N), .GROUP_SIZE(GS), .STAGGER_CYCLES(ST),
                  .PWR_STABLE_CYCLES(PSC), .CFG_RST(8'h02)) dut (
    .clk_i(clk), .rst_ni(rstN), .rto_i(rto), .sns_i(sns), .cfg(cfgIf),
    .core_oe_i(coreOe), .core_ie_i(coreIe),
    .pad_oe_o(padOe), .pad_ie_o(padIe), .pad_pe_o(padPe), .pad_ps_o(padPs),
    .pad_ds_o(padDs), .pad_sr_o(padSr), .pad_is_o(padIs), .bank_ready_o(ready)
  );

  // Second bank with a non-power-of-two pad count so out-of-range addresses exist
  pad_bank_ctrl #(.N_PADS(N2), .GROUP_SIZE(4), .STAGGER_CYCLES(2),
                  .PWR_STABLE_CYCLES(3), .CFG_RST(8'h02)) dut2 (
    .clk_i(clk), .rst_ni(rstN), .rto_i(rto), .sns_i(sns), .cfg(cfgIf2),
    .core_oe_i('1), .core_ie_i('1),
    .pad_oe_o(padOe2), .pad_ie_o(padIe2), .pad_pe_o(padPe2), .pad_ps_o(padPs2),
    .pad_ds_o(padDs2), .pad_sr_o(padSr2), .pad_is_o(padIs2), .bank_ready_o(ready2)
  );

  int checks = 0;
  int errors = 0;

  // Model state: consecutive qualifying high-power edges and a pending SAFE cycle
  int         hiRun = 0;
  bit         safeSkip = 0;
  logic [7:0] mCfg  [N];
  logic [7:0] mCfg2 [N2];
  logic [N-1:0]   eOe, eIe, ePe, ePs, eSr, eIs;
  logic [2*N-1:0] eDs;
  logic       eReady, eRvalid, eErr, eRvalid2, eErr2;
  logic [7:0] eRdata, eRdata2;
  bit         req2 = 0, we2 = 0;
  int         addr2 = 0;
  logic [7:0] wdata2 = 8'h00;

  function automatic int groupsOn(input int run);
    int g;
    if (run < PSC) return 0;
    g = (run - PSC) / ST + 1;
    return (g > NG) ? NG : g;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit r, input bit s,
                               input logic [N-1:0] oe, input logic [N-1:0] ie,
                               input bit req, input bit we, input int addr, input logic [7:0] wdata);
    bit pwr;
    bit en;
    int g;
    @(negedge clk);
    rstN = rst; rto = r; sns = s; coreOe = oe; coreIe = ie;
    cfgIf.req  = req;  cfgIf.we  = we;  cfgIf.addr  = 3'(addr);  cfgIf.wdata  = wdata;
    cfgIf2.req = req2; cfgIf2.we = we2; cfgIf2.addr = 4'(addr2); cfgIf2.wdata = wdata2;
    #1;
    checkOutput("gnt", 64'(cfgIf.gnt), 64'(req));
    checkOutput("gnt2", 64'(cfgIf2.gnt), 64'(req2));
    pwr = r & s;
    if (!rst) begin
      eOe = '0; eIe = '0; ePe = '0; ePs = '0; eSr = '0; eIs = '0; eDs = '0;
      eReady = 1'b0; eRvalid = 1'b0; eErr = 1'b0; eRdata = 8'h00;
      eRvalid2 = 1'b0; eErr2 = 1'b0; eRdata2 = 8'h00;
      hiRun = 0; safeSkip = 0;
      for (int p = 0; p < N; p++)  mCfg[p]  = 8'h02;
      for (int p = 0; p < N2; p++) mCfg2[p] = 8'h02;
    end else begin
      g = groupsOn(hiRun);
      for (int p = 0; p < N; p++) begin
        en = pwr && ((p / GS) < g);
        eOe[p] = en & oe[p] & mCfg[p][0];
        eIe[p] = en & ie[p] & mCfg[p][1];
        ePe[p] = en & mCfg[p][2];
        ePs[p] = en & mCfg[p][3];
        eDs[2*p +: 2] = en ? mCfg[p][5:4] : 2'b00;
        eSr[p] = en & mCfg[p][6];
        eIs[p] = en & mCfg[p][7];
      end
      eReady  = pwr && (g == NG);
      eRvalid = req;
      eErr    = req && (addr >= N);
      eRdata  = (req && !we && addr < N) ? mCfg[addr] : 8'h00;
      if (req && we && addr < N) mCfg[addr] = wdata;
      eRvalid2 = req2;
      eErr2    = req2 && (addr2 >= N2);
      eRdata2  = (req2 && !we2 && addr2 < N2) ? mCfg2[addr2] : 8'h00;
      if (req2 && we2 && addr2 < N2) mCfg2[addr2] = wdata2;
      if (safeSkip) begin
        safeSkip = 0;
        hiRun = 0;
      end else if (pwr) begin
        if (hiRun < 100000) hiRun++;
      end else begin
        safeSkip = (hiRun >= PSC);
        hiRun = 0;
      end
    end
    @(posedge clk);
    #1;
    checkOutput("pad_oe", 64'(padOe), 64'(eOe));
    checkOutput("pad_ie", 64'(padIe), 64'(eIe));
    checkOutput("pad_pe", 64'(padPe), 64'(ePe));
    checkOutput("pad_ps", 64'(padPs), 64'(ePs));
    checkOutput("pad_ds", 64'(padDs), 64'(eDs));
    checkOutput("pad_sr", 64'(padSr), 64'(eSr));
    checkOutput("pad_is", 64'(padIs), 64'(eIs));
    checkOutput("bank_ready", 64'(ready), 64'(eReady));
    checkOutput("rvalid", 64'(cfgIf.rvalid), 64'(eRvalid));
    checkOutput("err", 64'(cfgIf.err), 64'(eErr));
    checkOutput("rdata", 64'(cfgIf.rdata), 64'(eRdata));
    checkOutput("rvalid2", 64'(cfgIf2.rvalid), 64'(eRvalid2));
    checkOutput("err2", 64'(cfgIf2.err), 64'(eErr2));
    checkOutput("rdata2", 64'(cfgIf2.rdata), 64'(eRdata2));
  endtask

  task automatic applyIdle(input bit r, input bit s);
    applyStimulus(1'b1, r, s, 8'hFF, 8'hFF, 1'b0, 1'b0, 0, 8'h00);
  endtask

  // Raise power and count cycles until bank_ready is seen (-1 if it never comes)
  task automatic waitReady(input int maxCycles, output int lat);
    lat = -1;
    for (int c = 1; c <= maxCycles; c++) begin
      applyIdle(1'b1, 1'b1);
      if (ready === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    logic [7:0] ieSteps [4];
    bit r, s, rst, req, we;
    int addr;

    rstN = 1'b0; rto = 1'b0; sns = 1'b0; coreOe = '0; coreIe = '0;
    cfgIf.req = 1'b0;  cfgIf.we = 1'b0;  cfgIf.addr = '0;  cfgIf.wdata = '0;
    cfgIf2.req = 1'b0; cfgIf2.we = 1'b0; cfgIf2.addr = '0; cfgIf2.wdata = '0;

    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 0, 8'h00);
    checkOutput("dut2_reset_outputs",
                64'(|{padOe2, padIe2, padPe2, padPs2, padDs2, padSr2, padIs2, ready2}), 64'(0));
    applyIdle(1'b0, 1'b0);

    $display("[TB] power-up ramp");
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      applyIdle(1'b1, 1'b1);
      if (c == 17) ieSteps[0] = padIe;
      if (c == 21) ieSteps[1] = padIe;
      if (c == 25) ieSteps[2] = padIe;
      if (c == 29) ieSteps[3] = padIe;
      if (ready === 1'b1 && lat < 0) lat = c;
      if (c >= 29 && lat >= 0) break;
    end
    checkOutput("ready_latency", 64'(lat), 64'(29));
    checkOutput("ie_step0", 64'(ieSteps[0]), 64'(8'h03));
    checkOutput("ie_step1", 64'(ieSteps[1]), 64'(8'h0F));
    checkOutput("ie_step2", 64'(ieSteps[2]), 64'(8'h3F));
    checkOutput("ie_step3", 64'(ieSteps[3]), 64'(8'hFF));
    checkOutput("oe_stays_off", 64'(padOe), 64'(8'h00));

    $display("[TB] cfg write/read in ACTIVE");
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 3, 8'h3B);
    applyIdle(1'b1, 1'b1);
    checkOutput("w3_oe", 64'(padOe[3]), 64'(1));
    checkOutput("w3_pe", 64'(padPe[3]), 64'(0));
    checkOutput("w3_ps", 64'(padPs[3]), 64'(1));
    checkOutput("w3_ds", 64'(padDs[7:6]), 64'(2'b11));
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0, 3, 8'h00);
    checkOutput("r3_rvalid", 64'(cfgIf.rvalid), 64'(1));
    checkOutput("r3_rdata", 64'(cfgIf.rdata), 64'(8'h3B));

    $display("[TB] power drop during ramp");
    applyIdle(1'b0, 1'b0);
    applyIdle(1'b0, 1'b0);
    for (int c = 1; c <= 22; c++) applyIdle(1'b1, 1'b1);
    checkOutput("ramp_g1_ie", 64'(padIe), 64'(8'h0F));
    applyIdle(1'b1, 1'b0);
    checkOutput("drop_pads_zero", 64'(|{padOe, padIe, padPe, padPs, padDs, padSr, padIs}), 64'(0));
    waitReady(60, lat);
    checkOutput("restart_latency", 64'(lat), 64'(30));
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0, 3, 8'h00);
    checkOutput("r3_retained", 64'(cfgIf.rdata), 64'(8'h3B));

    $display("[TB] power glitch during WAIT");
    applyIdle(1'b0, 1'b0);
    applyIdle(1'b0, 1'b0);
    for (int c = 1; c <= 11; c++) applyIdle(1'b1, 1'b1);
    applyIdle(1'b0, 1'b1);
    waitReady(60, lat);
    checkOutput("wait_glitch_latency", 64'(lat), 64'(29));

    $display("[TB] out-of-range access");
    req2 = 1; we2 = 1; addr2 = 9; wdata2 = 8'hFF;
    applyIdle(1'b1, 1'b1);
    checkOutput("a9_rvalid", 64'(cfgIf2.rvalid), 64'(1));
    checkOutput("a9_err", 64'(cfgIf2.err), 64'(1));
    checkOutput("a9_rdata", 64'(cfgIf2.rdata), 64'(0));
    we2 = 0; addr2 = 8;
    applyIdle(1'b1, 1'b1);
    checkOutput("a8_rdata", 64'(cfgIf2.rdata), 64'(8'h02));
    checkOutput("a8_err", 64'(cfgIf2.err), 64'(0));
    req2 = 0;

    $display("[TB] reset while ACTIVE");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0, 3, 8'h00);
    checkOutput("rst_outputs_zero",
                64'(|{padOe, padIe, padPe, padPs, padDs, padSr, padIs, ready, cfgIf.rvalid}), 64'(0));
    for (int a = 0; a < N; a++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, a, 8'h00);
      checkOutput("rst_cfg_readback", 64'(cfgIf.rdata), 64'(8'h02));
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      r    = ($urandom_range(0, 59) != 0);
      s    = ($urandom_range(0, 59) != 0);
      rst  = ($urandom_range(0, 499) != 0);
      req  = ($urandom_range(0, 2) == 0);
      we   = 1'($urandom_range(0, 1));
      addr = int'($urandom_range(0, 7));
      req2 = ($urandom_range(0, 3) == 0);
      we2  = 1'($urandom_range(0, 1));
      addr2  = int'($urandom_range(0, 15));
      wdata2 = 8'($urandom);
      applyStimulus(rst, r, s, 8'($urandom), 8'($urandom), req, we, addr, 8'($urandom));
    end
    req2 = 0;
    applyIdle(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
